// File: rtl/rect_scene_ctrl.sv
// Rectangle scene controller: shadow/active descriptor banks with a vblank-synchronised
// commit, plus a per-pixel priority resolver producing a registered rgb.
module rect_scene_ctrl #(
    parameter int unsigned NUM_RECTS = 4,
    parameter int unsigned X_START   = 158,
    parameter int unsigned V_DISPLAY = 480,
    parameter logic [23:0] BG_COLOR  = 24'hFFFFFF,
    localparam int unsigned IDX_W    = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bright,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [9:0]       cfg_x0,
    input  logic [9:0]       cfg_x1,
    input  logic [9:0]       cfg_y0,
    input  logic [9:0]       cfg_y1,
    input  logic [23:0]      cfg_color,
    input  logic             commit_req,
    output logic             commit_busy,
    output logic             commit_done,
    output logic [23:0]      rgb
);

    typedef struct packed {
        logic        en;
        logic [9:0]  x0;
        logic [9:0]  x1;
        logic [9:0]  y0;
        logic [9:0]  y1;
        logic [23:0] color;
    } rect_t;

    typedef enum logic [1:0] {IDLE, PENDING, COPY, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] copy_idx_q, copy_idx_d;
    logic             in_vblank_d_q, in_vblank;
    logic             vblank_start;
    logic             cfg_ready_q, cfg_ready_d;
    logic             commit_busy_q, commit_busy_d;
    logic             commit_done_q, commit_done_d;
    logic [23:0]      rgb_q, rgb_d;
    rect_t            shadow_q [NUM_RECTS];
    rect_t            shadow_d [NUM_RECTS];
    rect_t            active_q [NUM_RECTS];
    rect_t            active_d [NUM_RECTS];

    logic [9:0]  x_pos;
    logic [23:0] color;
    logic        found;

    assign in_vblank    = (vcount >= 10'(V_DISPLAY));
    assign vblank_start = in_vblank && !in_vblank_d_q;

    always_comb begin
        state_d    = state_q;
        copy_idx_d = copy_idx_q;
        case (state_q)
            IDLE:    if (commit_req) state_d = PENDING;
            PENDING: if (vblank_start) begin
                state_d    = COPY;
                copy_idx_d = '0;
            end
            COPY: begin
                if (copy_idx_q == IDX_W'(NUM_RECTS - 1)) state_d = DONE;
                else copy_idx_d = copy_idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered from the next state so they read 0 during reset.
        cfg_ready_d   = (state_d == IDLE);
        commit_busy_d = (state_d == PENDING) || (state_d == COPY);
        commit_done_d = (state_d == DONE);
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            if (cfg_valid && cfg_ready_q && (cfg_idx == IDX_W'(i))) begin
                shadow_d[i].en    = cfg_en;
                shadow_d[i].x0    = cfg_x0;
                shadow_d[i].x1    = cfg_x1;
                shadow_d[i].y0    = cfg_y0;
                shadow_d[i].y1    = cfg_y1;
                shadow_d[i].color = cfg_color;
            end
            if ((state_q == COPY) && (copy_idx_q == IDX_W'(i))) active_d[i] = shadow_q[i];
        end
    end

    always_comb begin
        x_pos = hcount - 10'(X_START);
        color = BG_COLOR;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            if (!found && active_q[i].en &&
                (x_pos >= active_q[i].x0) && (x_pos < active_q[i].x1) &&
                (vcount >= active_q[i].y0) && (vcount < active_q[i].y1)) begin
                color = active_q[i].color;
                found = 1'b1;
            end
        end
        rgb_d = bright ? color : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            copy_idx_q    <= '0;
            in_vblank_d_q <= 1'b0;
            cfg_ready_q   <= 1'b0;
            commit_busy_q <= 1'b0;
            commit_done_q <= 1'b0;
            rgb_q         <= '0;
            for (int unsigned i = 0; i < NUM_RECTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            copy_idx_q    <= copy_idx_d;
            in_vblank_d_q <= in_vblank;
            cfg_ready_q   <= cfg_ready_d;
            commit_busy_q <= commit_busy_d;
            commit_done_q <= commit_done_d;
            rgb_q         <= rgb_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign commit_busy = commit_busy_q;
    assign commit_done = commit_done_q;
    assign rgb         = rgb_q;

endmodule
